// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;
  typedef logic [31:0] DATA_BUS;
  typedef struct packed {
    logic [31:0] pc;
    DATA_BUS     instr;
  } fetch_entry_t;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES = 4;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t with flush; DEPTH must be a power of two.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [AW:0]  count
);
  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    do_push = push && !flush;
    do_pop = pop && cnt_q != '0 && !flush;
    wr_d = flush ? '0 : wr_q + AW'(do_push);
    rd_d = flush ? '0 : rd_q + AW'(do_pop);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end
  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues in-order imem requests and buffers {pc, instr} for decode.
// Define FETCH_BYPASS_EN for a same-cycle response-to-decode path when the buffer is empty.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_target
);
  localparam int unsigned AW = $clog2(DEPTH);
  logic [31:0] pc_q, pc_d;
  logic [AW:0] drop_q, drop_d, fifo_cnt, outstanding;
  logic req_fire, rsp_keep, bypass, fifo_push, fifo_pop;
  fetch_entry_t req_e, tag_e, rsp_e, head_e;
  always_comb begin
    imem_req_valid = rst_n && !redirect && (fifo_cnt + outstanding < (AW+1)'(DEPTH));
    req_fire = imem_req_valid && imem_req_ready;
    rsp_keep = imem_rsp_valid && drop_q == '0 && !redirect;
`ifdef FETCH_BYPASS_EN
    bypass = rsp_keep && fifo_cnt == '0;
`else
    bypass = 1'b0;
`endif
    req_e = '{pc: pc_q, instr: '0};
    rsp_e = tag_e;
    rsp_e.instr = imem_rsp_data;
    instr_valid = fifo_cnt != '0 || bypass;
    {instr_pc, instr} = bypass ? rsp_e : (fifo_cnt != '0 ? head_e : '0);
    fifo_pop = instr_valid && instr_ready && !bypass;
    fifo_push = rsp_keep && !(bypass && instr_ready);
    pc_d = redirect ? (redirect_target & ~32'd3) : req_fire ? pc_q + 32'(INSTR_BYTES) : pc_q;
    // Every request still in flight at a redirect is stale, including ones already marked for drop.
    drop_d = redirect ? outstanding - (AW+1)'(imem_rsp_valid)
                      : drop_q - (AW+1)'(imem_rsp_valid && drop_q != '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q <= pc_d;
      drop_q <= drop_d;
    end
  end
  assign imem_req_addr = pc_q;
  // Tag FIFO occupancy doubles as the outstanding-request count.
  fetch_fifo #(.DEPTH(DEPTH)) u_tag (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .push(req_fire), .pop(imem_rsp_valid),
    .wdata(req_e), .rdata(tag_e), .count(outstanding)
  );
  fetch_fifo #(.DEPTH(DEPTH)) u_buf (
    .clk(clk), .rst_n(rst_n), .flush(redirect), .push(fifo_push), .pop(fifo_pop),
    .wdata(rsp_e), .rdata(head_e), .count(fifo_cnt)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch traffic against a queue-based model of the fetch stage.
module tb_fetch_unit;
  import fetch_unit_pkg::*;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid, instr_valid, instr_ready, redirect;
  logic [31:0] imem_req_addr, imem_rsp_data, instr, instr_pc, redirect_target;
  always #5 clk = ~clk;
  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect(redirect), .redirect_target(redirect_target)
  );
  typedef struct {logic [31:0] pc; bit drop;} fl_t;
  typedef struct {logic [31:0] addr; int due;} mr_t;
  fl_t infl[$];
  mr_t memq[$];
  fetch_entry_t mf[$];
  logic [31:0] popped[$];
  logic [31:0] fetch_pc, prog_pc;
  int cyc = 0, checks = 0, errors = 0, dut_reqs = 0;
  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic step(bit ir, bit rr, bit rd, logic [31:0] tgt, int lat);
    bit exp_rv, exp_iv;
    fl_t it;
    @(negedge clk);
    instr_ready = ir;
    imem_req_ready = rr;
    redirect = rd;
    redirect_target = tgt;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = mem_word(memq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data = $urandom;
    end
    #1;
    exp_rv = !rd && (mf.size() + infl.size() < DEPTH);
    exp_iv = mf.size() > 0;
    chk("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) chk("req_addr", imem_req_addr, fetch_pc);
    chk("instr_valid", instr_valid, exp_iv);
    if (exp_iv) begin
      chk("instr_pc", instr_pc, mf[0].pc);
      chk("instr", instr, mf[0].instr);
    end
    if (exp_iv && ir) begin
      chk("prog_order", instr_pc, prog_pc);
      popped.push_back(instr_pc);
      void'(mf.pop_front());
      prog_pc += 32'd4;
    end
    if (imem_rsp_valid) begin
      void'(memq.pop_front());
      if (infl.size() > 0) begin
        it = infl.pop_front();
        if (!it.drop && !rd) mf.push_back('{pc: it.pc, instr: mem_word(it.pc)});
      end
    end
    if (imem_req_valid && rr) begin
      memq.push_back('{addr: imem_req_addr, due: cyc + lat});
      dut_reqs++;
    end
    if (exp_rv && rr) begin
      infl.push_back('{pc: fetch_pc, drop: 1'b0});
      fetch_pc += 32'd4;
    end
    if (rd) begin
      mf.delete();
      foreach (infl[i]) infl[i].drop = 1'b1;
      fetch_pc = tgt & ~32'd3;
      prog_pc = tgt & ~32'd3;
    end
    cyc++;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    instr_ready = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    redirect = 1'b0;
    redirect_target = '0;
    infl.delete();
    memq.delete();
    mf.delete();
    popped.delete();
    fetch_pc = 32'h0;
    prog_pc = 32'h0;
    dut_reqs = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    logic [31:0] tgt;
    do_reset();
    step(1, 1, 0, 0, 1);
    chk("first_req_valid", imem_req_valid, 1);
    repeat (9) step(1, 1, 0, 0, 1);
    chk("seq_pc0", popped[0], 32'h0);
    chk("seq_pc1", popped[1], 32'h4);
    chk("seq_pc2", popped[2], 32'h8);
    do_reset();
    repeat (10) step(0, 1, 0, 0, 1);
    chk("stall_reqs", dut_reqs, 2);
    chk("stall_no_req", imem_req_valid, 0);
    repeat (3) step(1, 1, 0, 0, 1);
    chk("release_pc0", popped[0], 32'h0);
    chk("release_pc1", popped[1], 32'h4);
    do_reset();
    repeat (2) step(0, 1, 0, 0, 4);
    step(0, 1, 1, 32'h40, 1);
    repeat (12) step(1, 1, 0, 0, 1);
    chk("redir_pc0", popped[0], 32'h40);
    chk("redir_pc1", popped[1], 32'h44);
    do_reset();
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 2);
    step(0, 1, 0, 0, 1);
    chk("same_cycle_rsp", imem_rsp_valid, 0);
    step(1, 1, 1, 32'h100, 1);
    chk("same_cycle_rsp_arrived", imem_rsp_valid, 1);
    repeat (6) step(1, 1, 0, 0, 1);
    chk("same_cycle_kept", popped[0], 32'h0);
    chk("same_cycle_target", popped[1], 32'h100);
    do_reset();
    step(1, 1, 1, 32'hFFFF_FFFF, 1);
    step(1, 1, 0, 0, 1);
    chk("wrap_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    step(1, 1, 0, 0, 1);
    chk("wrap_addr_zero", imem_req_addr, 32'h0);
    repeat (6) step(1, 1, 0, 0, 1);
    chk("wrap_pop_top", popped[0], 32'hFFFF_FFFC);
    chk("wrap_pop_zero", popped[1], 32'h0);
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      tgt = ($urandom % 8 == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step($urandom % 4 != 0, $urandom % 3 != 0, $urandom % 20 == 0, tgt, 1 + $urandom % 4);
    end
    do_reset();
    repeat (6) step(0, 1, 0, 0, 1);
    chk("full_valid", instr_valid, 1);
    chk("full_no_req", imem_req_valid, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req_valid", imem_req_valid, 0);
    chk("async_req_addr", imem_req_addr, 32'h0);
    chk("async_instr_valid", instr_valid, 0);
    chk("async_instr", instr, 32'h0);
    chk("async_instr_pc", instr_pc, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
